// File: rtl/inst_fetch_unit.sv
// ----------------------------------------------------------------------------
// inst_fetch_unit
// Instruction fetch stage. It owns the program counter, fetches one 32-bit
// word at a time from instruction memory with a req/ready handshake, and
// holds each word until the decoder consumes it. On consume it picks the
// next PC in priority order: jump, then taken branch, then sequential. A
// memory that stays silent for MAX_WAIT fetch cycles latches a sticky
// fetch_error, and only reset clears it.
//
// Ports
//   clk_i, reset_i     clock, synchronous active-high reset
//   imem_req_o         fetch request (combinational from state)
//   imem_addr_o        fetch byte address, equal to pc_o (combinational)
//   imem_ready_i       memory data valid this cycle
//   imem_rdata_i       memory instruction word
//   instruction_o      registered instruction word sent to the decoder
//   inst_valid_o       instruction_o holds an unconsumed word
//   pc_o               PC of the current fetch or issue
//   pc_plus4_o         pc_o + 4, modulo 2^32 (combinational)
//   stall_i            downstream stage cannot consume this cycle
//   jump_i             jump redirect for the issuing word
//   jump_immediate_i   26-bit jump target field
//   branch_taken_i     taken-branch redirect for the issuing word
//   branch_offset_i    signed branch offset, counted in words
//   fetch_error_o      sticky memory-timeout flag
//   retired_count_o    number of words consumed since reset (wraps)
// ----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_o,
    output logic        inst_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [25:0] jump_immediate_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_offset_i,
    output logic        fetch_error_o,
    output logic [31:0] retired_count_o
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [XLEN-1:0]     instruction_q, instruction_d;
    logic                inst_valid_q, inst_valid_d;
    logic                fetch_error_q, fetch_error_d;
    logic [XLEN-1:0]     retired_q, retired_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic [XLEN-1:0]     pc_plus4;
    logic [XLEN-1:0]     branch_disp;
    logic [XLEN-1:0]     next_pc;
    logic [WAIT_W-1:0]   wait_inc;

    // Sequential PC and redirect target selection
    assign pc_plus4    = pc_q + XLEN'(4);
    assign branch_disp = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};
    assign wait_inc    = wait_q + WAIT_W'(1);

    always_comb begin
        next_pc = pc_plus4;
        if (jump_i) begin
            next_pc = {pc_plus4[31:28], jump_immediate_i, 2'b00};
        end else if (branch_taken_i) begin
            next_pc = pc_plus4 + branch_disp;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instruction_d = instruction_q;
        inst_valid_d  = inst_valid_q;
        fetch_error_d = fetch_error_q;
        retired_d     = retired_q;
        wait_d        = wait_q;

        unique case (state_q)
            ST_FETCH: begin
                if (imem_ready_i) begin
                    instruction_d = imem_rdata_i;
                    inst_valid_d  = 1'b1;
                    wait_d        = '0;
                    state_d       = ST_ISSUE;
                end else if (wait_inc == WAIT_W'(MAX_WAIT)) begin
                    // Last permitted silent cycle: give up for good
                    wait_d        = wait_inc;
                    fetch_error_d = 1'b1;
                    state_d       = ST_ERROR;
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_ISSUE: begin
                // Redirect inputs only matter in the consume cycle
                if (!stall_i) begin
                    pc_d         = next_pc;
                    retired_d    = retired_q + XLEN'(1);
                    inst_valid_d = 1'b0;
                    wait_d       = '0;
                    state_d      = ST_FETCH;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            instruction_q <= '0;
            inst_valid_q  <= 1'b0;
            fetch_error_q <= 1'b0;
            retired_q     <= '0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instruction_q <= instruction_d;
            inst_valid_q  <= inst_valid_d;
            fetch_error_q <= fetch_error_d;
            retired_q     <= retired_d;
            wait_q        <= wait_d;
        end
    end

    // Request is suppressed while reset is held so no fetch escapes early
    assign imem_req_o      = (state_q == ST_FETCH) && !reset_i;
    assign imem_addr_o     = pc_q;
    assign pc_plus4_o      = pc_plus4;
    assign pc_o            = pc_q;
    assign instruction_o   = instruction_q;
    assign inst_valid_o    = inst_valid_q;
    assign fetch_error_o   = fetch_error_q;
    assign retired_count_o = retired_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed vector table plus randomized run against a reference model for
// inst_fetch_unit. A second instance with RESET_PC = 0xFFFF_FFFC covers PC
// wraparound.
// ----------------------------------------------------------------------------
module tb_inst_fetch_unit;

    localparam int unsigned TB_MAX_WAIT = 4;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam int unsigned N_RAND      = 3000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        jump;
    logic [25:0] jump_immediate;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        fetch_error;
    logic [31:0] retired_count;

    // Second instance for the wraparound case
    logic        reset2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ready2;
    logic [31:0] instruction2;
    logic        inst_valid2;
    logic [31:0] pc2;
    logic [31:0] pc_plus4_2;
    logic        fetch_error2;
    logic [31:0] retired_count2;

    int n_chk;
    int n_fail;

    inst_fetch_unit #(
        .RESET_PC (TB_RESET_PC),
        .MAX_WAIT (TB_MAX_WAIT)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_ready_i     (imem_ready),
        .imem_rdata_i     (imem_rdata),
        .instruction_o    (instruction),
        .inst_valid_o     (inst_valid),
        .pc_o             (pc),
        .pc_plus4_o       (pc_plus4),
        .stall_i          (stall),
        .jump_i           (jump),
        .jump_immediate_i (jump_immediate),
        .branch_taken_i   (branch_taken),
        .branch_offset_i  (branch_offset),
        .fetch_error_o    (fetch_error),
        .retired_count_o  (retired_count)
    );

    inst_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .MAX_WAIT (15)
    ) dut_wrap (
        .clk_i            (clk),
        .reset_i          (reset2),
        .imem_req_o       (imem_req2),
        .imem_addr_o      (imem_addr2),
        .imem_ready_i     (imem_ready2),
        .imem_rdata_i     (32'h1234_5678),
        .instruction_o    (instruction2),
        .inst_valid_o     (inst_valid2),
        .pc_o             (pc2),
        .pc_plus4_o       (pc_plus4_2),
        .stall_i          (1'b0),
        .jump_i           (1'b0),
        .jump_immediate_i (26'd0),
        .branch_taken_i   (1'b0),
        .branch_offset_i  (16'd0),
        .fetch_error_o    (fetch_error2),
        .retired_count_o  (retired_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] rdata;
        logic        stl;
        logic        jmp;
        logic [25:0] jimm;
        logic        br;
        logic [15:0] off;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_ret;
        logic        e_err;
        logic        e_req;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic rdy, input logic [31:0] rdata,
                       input logic stl, input logic jmp, input logic [25:0] jimm,
                       input logic br, input logic [15:0] off,
                       input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                       input logic [31:0] er, input logic ee, input logic eq);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rdata = rdata; v.stl = stl;
        v.jmp = jmp; v.jimm = jimm; v.br = br; v.off = off;
        v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_ret = er;
        v.e_err = ee; v.e_req = eq;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic [31:0] rdata,
                         input logic stl, input logic jmp, input logic [25:0] jimm,
                         input logic br, input logic [15:0] off);
        reset = rst; imem_ready = rdy; imem_rdata = rdata; stall = stl;
        jump = jmp; jump_immediate = jimm; branch_taken = br; branch_offset = off;
    endtask

    // Reference model: a word is either pending from memory or held for the decoder
    logic        m_has_word;
    logic        m_err;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ret;
    int          m_silent;

    function automatic logic [31:0] redirect(input logic [31:0] cur, input logic jmp,
                                             input logic [25:0] jimm, input logic br,
                                             input logic [15:0] off);
        logic [31:0] seq;
        int          disp;
        seq = cur + 32'd4;
        if (jmp) return (seq & 32'hF000_0000) | (32'(jimm) * 32'd4);
        if (br) begin
            disp = int'($signed(off)) * 4;
            return seq + 32'(disp);
        end
        return seq;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_has_word = 1'b0; m_err = 1'b0; m_pc = TB_RESET_PC;
            m_instr = 32'd0; m_ret = 32'd0; m_silent = 0;
        end else if (m_err) begin
            m_err = 1'b1;
        end else if (!m_has_word) begin
            if (imem_ready) begin
                m_instr = imem_rdata; m_has_word = 1'b1; m_silent = 0;
            end else begin
                m_silent++;
                if (m_silent >= int'(TB_MAX_WAIT)) m_err = 1'b1;
            end
        end else if (!stall) begin
            m_pc = redirect(m_pc, jump, jump_immediate, branch_taken, branch_offset);
            m_ret = m_ret + 32'd1;
            m_has_word = 1'b0;
            m_silent = 0;
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset2 = 1'b1;
        imem_ready2 = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // rst rdy rdata stall jmp jimm br off | valid instr pc ret err req
        add(1,0,32'h0,0,0,26'h0,0,16'h0,        0,32'h0,32'h00,0,0,0);
        add(0,1,32'hA5A5_0000,0,0,26'h0,0,16'h0,1,32'hA5A5_0000,32'h00,0,0,0);
        add(0,1,32'hDEAD_BEEF,0,0,26'h0,0,16'h0,0,32'hA5A5_0000,32'h04,1,0,1);
        add(0,1,32'hA5A5_0004,0,0,26'h0,0,16'h0,1,32'hA5A5_0004,32'h04,1,0,0);
        add(0,1,32'hDEAD_BEEF,0,0,26'h0,0,16'h0,0,32'hA5A5_0004,32'h08,2,0,1);
        add(0,1,32'hA5A5_0008,0,0,26'h0,0,16'h0,1,32'hA5A5_0008,32'h08,2,0,0);
        add(0,1,32'hDEAD_BEEF,0,0,26'h0,0,16'h0,0,32'hA5A5_0008,32'h0C,3,0,1);
        add(0,1,32'hA5A5_000C,0,0,26'h0,0,16'h0,1,32'hA5A5_000C,32'h0C,3,0,0);
        add(0,1,32'hDEAD_BEEF,0,0,26'h0,0,16'h0,0,32'hA5A5_000C,32'h10,4,0,1);
        add(0,1,32'hA5A5_0010,0,0,26'h0,0,16'h0,1,32'hA5A5_0010,32'h10,4,0,0);
        add(0,0,32'h0,0,1,26'h40,0,16'h0,       0,32'hA5A5_0010,32'h100,5,0,1);
        add(0,1,32'h1111_1111,0,0,26'h0,0,16'h0,1,32'h1111_1111,32'h100,5,0,0);
        add(0,0,32'h0,0,1,26'h40,1,16'h0003,    0,32'h1111_1111,32'h100,6,0,1);
        add(0,1,32'h2222_2222,0,0,26'h0,0,16'h0,1,32'h2222_2222,32'h100,6,0,0);
        add(0,0,32'h0,0,1,26'h8,0,16'h0,        0,32'h2222_2222,32'h20,7,0,1);
        add(0,1,32'h3333_3333,0,0,26'h0,0,16'h0,1,32'h3333_3333,32'h20,7,0,0);
        add(0,0,32'h0,0,0,26'h0,1,16'hFFFE,     0,32'h3333_3333,32'h1C,8,0,1);
        add(0,1,32'h4444_4444,0,0,26'h0,0,16'h0,1,32'h4444_4444,32'h1C,8,0,0);
        add(0,0,32'h0,0,1,26'h8,0,16'h0,        0,32'h4444_4444,32'h20,9,0,1);
        add(0,1,32'h5555_5555,0,0,26'h0,0,16'h0,1,32'h5555_5555,32'h20,9,0,0);
        add(0,0,32'h0,0,0,26'h0,1,16'h0003,     0,32'h5555_5555,32'h30,10,0,1);
        add(0,1,32'h6666_6666,0,0,26'h0,0,16'h0,1,32'h6666_6666,32'h30,10,0,0);
        add(0,1,32'h1234_5678,1,1,26'h3FF_FFFF,0,16'h0,   1,32'h6666_6666,32'h30,10,0,0);
        add(0,1,32'h1234_5678,1,0,26'h0,1,16'h7FFF,       1,32'h6666_6666,32'h30,10,0,0);
        add(0,0,32'h1234_5678,1,1,26'h155_5555,1,16'h8000,1,32'h6666_6666,32'h30,10,0,0);
        add(0,1,32'h1234_5678,1,0,26'h0,0,16'h0,          1,32'h6666_6666,32'h30,10,0,0);
        add(0,1,32'h1234_5678,1,1,26'h1,1,16'h1,          1,32'h6666_6666,32'h30,10,0,0);
        add(0,0,32'h0,0,0,26'h0,0,16'h0,        0,32'h6666_6666,32'h34,11,0,1);
        add(0,0,32'h0,0,0,26'h0,0,16'h0,        0,32'h6666_6666,32'h34,11,0,1);
        add(0,0,32'h0,0,0,26'h0,0,16'h0,        0,32'h6666_6666,32'h34,11,0,1);
        add(0,0,32'h0,0,0,26'h0,0,16'h0,        0,32'h6666_6666,32'h34,11,0,1);
        add(0,1,32'h7777_7777,0,0,26'h0,0,16'h0,1,32'h7777_7777,32'h34,11,0,0);
        add(0,0,32'h0,0,0,26'h0,0,16'h0,        0,32'h7777_7777,32'h38,12,0,1);
        add(1,1,32'h8888_8888,0,0,26'h0,0,16'h0,0,32'h0,32'h0,0,0,0);
        add(0,0,32'h0,0,0,26'h0,0,16'h0,        0,32'h0,32'h0,0,0,1);
        add(0,0,32'h0,0,0,26'h0,0,16'h0,        0,32'h0,32'h0,0,0,1);
        add(0,0,32'h0,0,0,26'h0,0,16'h0,        0,32'h0,32'h0,0,0,1);
        add(0,0,32'h0,0,0,26'h0,0,16'h0,        0,32'h0,32'h0,0,1,0);
        add(0,1,32'h0000_0099,0,0,26'h0,0,16'h0,0,32'h0,32'h0,0,1,0);
        add(0,1,32'h0000_0099,0,0,26'h0,0,16'h0,0,32'h0,32'h0,0,1,0);
        add(0,1,32'h0000_0099,0,0,26'h0,0,16'h0,0,32'h0,32'h0,0,1,0);
        add(1,0,32'h0,0,0,26'h0,0,16'h0,        0,32'h0,32'h0,0,0,0);
        add(0,1,32'h9999_AAAA,0,0,26'h0,0,16'h0,1,32'h9999_AAAA,32'h0,0,0,0);

        // Directed table
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].rdy, vq[i].rdata, vq[i].stl, vq[i].jmp,
                  vq[i].jimm, vq[i].br, vq[i].off);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.inst_valid", i), 32'(inst_valid), 32'(vq[i].e_valid));
            chk($sformatf("vec%0d.instruction", i), instruction, vq[i].e_instr);
            chk($sformatf("vec%0d.pc", i), pc, vq[i].e_pc);
            chk($sformatf("vec%0d.imem_addr", i), imem_addr, vq[i].e_pc);
            chk($sformatf("vec%0d.pc_plus4", i), pc_plus4, vq[i].e_pc + 32'd4);
            chk($sformatf("vec%0d.retired", i), retired_count, vq[i].e_ret);
            chk($sformatf("vec%0d.fetch_error", i), 32'(fetch_error), 32'(vq[i].e_err));
            chk($sformatf("vec%0d.imem_req", i), 32'(imem_req), 32'(vq[i].e_req));
        end

        // PC wraparound on the second instance
        @(posedge clk);
        #1;
        chk("wrap.reset_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap.reset_pc_plus4", pc_plus4_2, 32'h0000_0000);
        chk("wrap.reset_req", 32'(imem_req2), 32'd0);
        reset2 = 1'b0;
        imem_ready2 = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap.issue_valid", 32'(inst_valid2), 32'd1);
        chk("wrap.issue_instr", instruction2, 32'h1234_5678);
        @(posedge clk);
        #1;
        chk("wrap.next_pc", pc2, 32'h0000_0000);
        chk("wrap.next_addr", imem_addr2, 32'h0000_0000);
        chk("wrap.next_req", 32'(imem_req2), 32'd1);
        chk("wrap.retired", retired_count2, 32'd1);
        chk("wrap.no_error", 32'(fetch_error2), 32'd0);

        // Randomized run against the model
        for (int n = 0; n < int'(N_RAND); n++) begin
            drive((n == 0) || ($urandom_range(0, 299) == 0),
                  $urandom_range(0, 3) != 0,
                  $urandom,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0,
                  26'($urandom),
                  $urandom_range(0, 3) == 0,
                  16'($urandom));
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("rnd%0d.inst_valid", n), 32'(inst_valid), 32'(m_has_word));
            chk($sformatf("rnd%0d.instruction", n), instruction, m_instr);
            chk($sformatf("rnd%0d.pc", n), pc, m_pc);
            chk($sformatf("rnd%0d.imem_addr", n), imem_addr, m_pc);
            chk($sformatf("rnd%0d.pc_plus4", n), pc_plus4, m_pc + 32'd4);
            chk($sformatf("rnd%0d.retired", n), retired_count, m_ret);
            chk($sformatf("rnd%0d.fetch_error", n), 32'(fetch_error), 32'(m_err));
            chk($sformatf("rnd%0d.imem_req", n), 32'(imem_req),
                32'(!m_has_word && !m_err && !reset));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
